nave_player: RTL and testbench

//  Player-ship controller and renderer for the VGA game screen: per-frame movement from buttons,

---
 rtl/nave_pkg.sv | 42 ++++
 rtl/nave_sprite_rom.sv | 26 ++
 rtl/nave_player.sv | 221 ++++++++++++++++++++++
 tb/tb_nave_player.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nave_pkg.sv
`default_nettype none
// ============================================================================
// Module : nave_pkg
// Brief  : Player-ship state encoding, 11x11 ship bitmap and colour constants.
// Rev    : 1.0  initial release
// ============================================================================
package nave_pkg;

   typedef enum logic [1:0] {
      ST_ALIVE     = 2'd0,
      ST_EXPLODING = 2'd1,
      ST_DEAD      = 2'd2,
      ST_GAME_OVER = 2'd3
   } nave_state_t;

   localparam int          c_BMP_SIZE  = 11;
   localparam logic [23:0] c_COL_WHITE = 24'hFFFFFF;
   localparam logic [23:0] c_COL_RED   = 24'hFF0000;
   localparam logic [23:0] c_COL_BLACK = 24'h000000;

   // Bit 10 of each row is the leftmost column.
   function automatic logic [10:0] bitmap_row(input logic [3:0] row);
      logic [10:0] bits;
      case (row)
         4'd0:    bits = 11'h020;
         4'd1:    bits = 11'h070;
         4'd2:    bits = 11'h0F8;
         4'd3:    bits = 11'h1DC;
         4'd4:    bits = 11'h38E;
         4'd5:    bits = 11'h7FF;
         4'd6:    bits = 11'h7FF;
         4'd7:    bits = 11'h7FF;
         4'd8:    bits = 11'h7FF;
         4'd9:    bits = 11'h104;
         4'd10:   bits = 11'h104;
         default: bits = 11'h000;
      endcase
      return bits;
   endfunction

endpackage
`default_nettype wire

// File: rtl/nave_sprite_rom.sv
`default_nettype none
// ============================================================================
// Module : nave_sprite_rom
// Brief  : Combinational row/column lookup into the ship bitmap.
// Rev    : 1.0  initial release
// ============================================================================
module nave_sprite_rom
   import nave_pkg::*;
(
   input  logic [3:0] i_row,
   input  logic [3:0] i_col,
   output logic       o_bit
);

   logic [10:0] w_row_bits;

   always_comb begin
      w_row_bits = bitmap_row(i_row);
      o_bit      = 1'b0;
      if (i_col < 4'd11) begin
         o_bit = w_row_bits[4'd10 - i_col];
      end
   end

endmodule
`default_nettype wire

// File: rtl/nave_player.sv
`default_nettype none
// ============================================================================
// Module : nave_player
// Brief  : Player ship movement, shot launch, hit/explode/respawn FSM, renderer.
// Rev    : 1.0  initial release
// ============================================================================
module nave_player
   import nave_pkg::*;
#(
   parameter int SCALE          = 2,
   parameter int START_Y        = 490,
   parameter int X_START        = 309,
   parameter int X_MAX          = 640,
   parameter int SPEED          = 4,
   parameter int FIRE_COOLDOWN  = 15,
   parameter int EXPLODE_FRAMES = 32,
   parameter int RESPAWN_FRAMES = 60,
   parameter int LIVES          = 3,
   parameter int V_TICK_LINE    = 480
)(
   input  logic       clk,
   input  logic       reset,
   input  logic [9:0] h_counter,
   input  logic [9:0] v_counter,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_fire,
   input  logic       hit,
   input  logic       shot_ready,
   output logic       shot_valid,
   output logic [9:0] shot_x,
   output logic [9:0] pos_x,
   output logic [1:0] lives,
   output logic       game_over,
   output logic       sprite_on,
   output logic [7:0] R,
   output logic [7:0] G,
   output logic [7:0] B
);

   localparam int c_SHIP_W  = c_BMP_SIZE * SCALE;
   localparam int c_SHIFT   = $clog2(SCALE);
   localparam int c_CNT_W   = $clog2(((EXPLODE_FRAMES > RESPAWN_FRAMES) ?
                                       EXPLODE_FRAMES : RESPAWN_FRAMES) + 1);
   localparam int c_COOL_W  = $clog2(FIRE_COOLDOWN + 1);

   localparam logic [10:0]         c_X_LIM     = 11'(X_MAX - c_SHIP_W);
   localparam logic [9:0]          c_X_START   = 10'(X_START);
   localparam logic [9:0]          c_SPEED     = 10'(SPEED);
   localparam logic [9:0]          c_SHOT_OFS  = 10'(5 * SCALE);
   localparam logic [9:0]          c_TICK_LINE = 10'(V_TICK_LINE);
   localparam logic [10:0]         c_Y0        = 11'(START_Y);
   localparam logic [10:0]         c_Y1        = 11'(START_Y + c_SHIP_W);
   localparam logic [10:0]         c_W11       = 11'(c_SHIP_W);
   localparam logic [c_COOL_W-1:0] c_COOL      = c_COOL_W'(FIRE_COOLDOWN);
   localparam logic [c_CNT_W-1:0]  c_EXPL      = c_CNT_W'(EXPLODE_FRAMES);
   localparam logic [c_CNT_W-1:0]  c_RESP      = c_CNT_W'(RESPAWN_FRAMES);

   nave_state_t         r_state, w_nxt_state;
   logic [9:0]          r_pos_x, w_nxt_pos;
   logic [1:0]          r_lives, w_nxt_lives;
   logic [c_CNT_W-1:0]  r_cnt, w_nxt_cnt, w_cnt_dec;
   logic [c_COOL_W-1:0] r_cooldown, w_nxt_cool;
   logic                r_shot_valid, w_nxt_sv;
   logic [9:0]          r_shot_x, w_nxt_sx;
   logic                r_fire_d, r_tick_d;
   logic [23:0]         r_rgb, w_rgb;
   logic                r_sprite_on, w_drawn;

   logic        w_tick_cond, w_frame_tick, w_fire_edge;
   logic [10:0] w_pos_inc;

   assign w_tick_cond  = (h_counter == 10'd0) && (v_counter == c_TICK_LINE);
   assign w_frame_tick = w_tick_cond & ~r_tick_d;
   assign w_fire_edge  = btn_fire & ~r_fire_d;
   assign w_pos_inc    = {1'b0, r_pos_x} + {1'b0, c_SPEED};
   assign w_cnt_dec    = r_cnt - 1'b1;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_ALIVE;
         r_pos_x      <= c_X_START;
         r_lives      <= 2'(LIVES);
         r_cnt        <= '0;
         r_cooldown   <= '0;
         r_shot_valid <= 1'b0;
         r_shot_x     <= '0;
         r_fire_d     <= 1'b0;
         r_tick_d     <= 1'b0;
      end else begin
         r_state      <= w_nxt_state;
         r_pos_x      <= w_nxt_pos;
         r_lives      <= w_nxt_lives;
         r_cnt        <= w_nxt_cnt;
         r_cooldown   <= w_nxt_cool;
         r_shot_valid <= w_nxt_sv;
         r_shot_x     <= w_nxt_sx;
         r_fire_d     <= btn_fire;
         r_tick_d     <= w_tick_cond;
      end
   end

   always_comb begin
      w_nxt_state = r_state;
      w_nxt_pos   = r_pos_x;
      w_nxt_lives = r_lives;
      w_nxt_cnt   = r_cnt;
      w_nxt_cool  = r_cooldown;
      w_nxt_sv    = r_shot_valid;
      w_nxt_sx    = r_shot_x;

      if (w_frame_tick && (r_cooldown != '0)) begin
         w_nxt_cool = r_cooldown - 1'b1;
      end
      // A pending shot survives the explosion and may still be accepted.
      if (r_shot_valid && shot_ready) begin
         w_nxt_sv   = 1'b0;
         w_nxt_cool = c_COOL;
      end

      case (r_state)
         ST_ALIVE: begin
            if (hit) begin
               w_nxt_state = ST_EXPLODING;
               w_nxt_lives = r_lives - 2'd1;
               w_nxt_cnt   = c_EXPL;
            end else begin
               if (w_frame_tick) begin
                  if (btn_left && !btn_right) begin
                     w_nxt_pos = (r_pos_x < c_SPEED) ? 10'd0 : (r_pos_x - c_SPEED);
                  end else if (btn_right && !btn_left) begin
                     w_nxt_pos = (w_pos_inc > c_X_LIM) ? c_X_LIM[9:0] : w_pos_inc[9:0];
                  end
               end
               if (w_fire_edge && (r_cooldown == '0) && !r_shot_valid) begin
                  w_nxt_sv = 1'b1;
                  w_nxt_sx = r_pos_x + c_SHOT_OFS;
               end
            end
         end
         ST_EXPLODING: begin
            if (w_frame_tick) begin
               if (w_cnt_dec == '0) begin
                  if (r_lives != 2'd0) begin
                     w_nxt_state = ST_DEAD;
                     w_nxt_cnt   = c_RESP;
                  end else begin
                     w_nxt_state = ST_GAME_OVER;
                     w_nxt_cnt   = '0;
                  end
               end else begin
                  w_nxt_cnt = w_cnt_dec;
               end
            end
         end
         ST_DEAD: begin
            if (w_frame_tick) begin
               if (w_cnt_dec == '0) begin
                  w_nxt_state = ST_ALIVE;
                  w_nxt_pos   = c_X_START;
                  w_nxt_cool  = '0;
                  w_nxt_cnt   = '0;
               end else begin
                  w_nxt_cnt = w_cnt_dec;
               end
            end
         end
         default: begin
            w_nxt_state = ST_GAME_OVER;
         end
      endcase
   end

   // Sprite lookup: 11-bit compares so the box edge never wraps at column 1023.
   logic [10:0] w_h11, w_v11, w_pos11, w_dx, w_dy;
   logic [3:0]  w_row, w_col;
   logic        w_in_box, w_bit;

   assign w_h11    = {1'b0, h_counter};
   assign w_v11    = {1'b0, v_counter};
   assign w_pos11  = {1'b0, r_pos_x};
   assign w_dx     = w_h11 - w_pos11;
   assign w_dy     = w_v11 - c_Y0;
   assign w_col    = 4'(w_dx >> c_SHIFT);
   assign w_row    = 4'(w_dy >> c_SHIFT);
   assign w_in_box = (w_h11 >= w_pos11) && (w_h11 < (w_pos11 + c_W11)) &&
                     (w_v11 >= c_Y0) && (w_v11 < c_Y1);

   nave_sprite_rom u_rom (
      .i_row (w_row),
      .i_col (w_col),
      .o_bit (w_bit)
   );

   assign w_drawn = w_in_box && w_bit &&
                    ((r_state == ST_ALIVE) || ((r_state == ST_EXPLODING) && r_cnt[2]));
   assign w_rgb   = !w_drawn ? c_COL_BLACK :
                    ((r_state == ST_ALIVE) ? c_COL_WHITE : c_COL_RED);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rgb       <= c_COL_BLACK;
         r_sprite_on <= 1'b0;
      end else begin
         r_rgb       <= w_rgb;
         r_sprite_on <= w_drawn;
      end
   end

   assign shot_valid = r_shot_valid;
   assign shot_x     = r_shot_x;
   assign pos_x      = r_pos_x;
   assign lives      = r_lives;
   assign game_over  = (r_state == ST_GAME_OVER);
   assign sprite_on  = r_sprite_on;
   assign R          = r_rgb[23:16];
   assign G          = r_rgb[15:8];
   assign B          = r_rgb[7:0];

endmodule
`default_nettype wire

// File: tb/tb_nave_player.sv
`default_nettype none
// ============================================================================
// Module : tb_nave_player
// Brief  : Directed, table-driven self-checking bench for nave_player.
// Rev    : 1.0  initial release
// ============================================================================
module tb_nave_player;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [9:0] h = 10'd100, v = 10'd100;
   logic       btn_left = 1'b0, btn_right = 1'b0, btn_fire = 1'b0;
   logic       hit = 1'b0, shot_ready = 1'b0;
   logic       shot_valid, game_over, sprite_on;
   logic [9:0] shot_x, pos_x;
   logic [1:0] lives;
   logic [7:0] R, G, B;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   nave_player dut (
      .clk        (clk),
      .reset      (reset),
      .h_counter  (h),
      .v_counter  (v),
      .btn_left   (btn_left),
      .btn_right  (btn_right),
      .btn_fire   (btn_fire),
      .hit        (hit),
      .shot_ready (shot_ready),
      .shot_valid (shot_valid),
      .shot_x     (shot_x),
      .pos_x      (pos_x),
      .lives      (lives),
      .game_over  (game_over),
      .sprite_on  (sprite_on),
      .R          (R),
      .G          (G),
      .B          (B)
   );

   typedef struct {
      logic [9:0]  ph;
      logic [9:0]  pv;
      logic [23:0] rgb;
      logic        on;
   } pix_t;

   typedef struct {
      logic       l;
      logic       r;
      logic [9:0] pos;
   } mv_t;

   pix_t ptab[15];
   mv_t  mtab[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic tick();
      h = 10'd0;
      v = 10'd480;
      step();
      h = 10'd100;
      v = 10'd100;
      step();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic pix(input string name, input logic [9:0] ph, input logic [9:0] pv,
                      input logic [23:0] er, input logic eo);
      h = ph;
      v = pv;
      step();
      chk({name, "_rgb"}, {8'h0, R, G, B}, {8'h0, er});
      chk({name, "_on"}, {31'd0, sprite_on}, {31'd0, eo});
      h = 10'd100;
      v = 10'd100;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_pos"}, {22'd0, pos_x}, 32'd309);
      chk({tag, "_lives"}, {30'd0, lives}, 32'd3);
      chk({tag, "_sv"}, {31'd0, shot_valid}, 32'd0);
      chk({tag, "_go"}, {31'd0, game_over}, 32'd0);
      chk({tag, "_on"}, {31'd0, sprite_on}, 32'd0);
      chk({tag, "_rgb"}, {8'h0, R, G, B}, 32'd0);
   endtask

   initial begin
      // Ship at 309: box x [309,331), y [490,512), 2x2 pixels per bitmap cell.
      ptab[0]  = '{10'd100, 10'd100, 24'h000000, 1'b0};
      ptab[1]  = '{10'd309, 10'd490, 24'h000000, 1'b0};
      ptab[2]  = '{10'd314, 10'd490, 24'h000000, 1'b0};
      ptab[3]  = '{10'd319, 10'd490, 24'hFFFFFF, 1'b1};
      ptab[4]  = '{10'd320, 10'd490, 24'hFFFFFF, 1'b1};
      ptab[5]  = '{10'd321, 10'd490, 24'h000000, 1'b0};
      ptab[6]  = '{10'd309, 10'd500, 24'hFFFFFF, 1'b1};
      ptab[7]  = '{10'd330, 10'd500, 24'hFFFFFF, 1'b1};
      ptab[8]  = '{10'd331, 10'd500, 24'h000000, 1'b0};
      ptab[9]  = '{10'd308, 10'd500, 24'h000000, 1'b0};
      ptab[10] = '{10'd319, 10'd489, 24'h000000, 1'b0};
      ptab[11] = '{10'd313, 10'd511, 24'hFFFFFF, 1'b1};
      ptab[12] = '{10'd319, 10'd496, 24'h000000, 1'b0};
      ptab[13] = '{10'd311, 10'd498, 24'hFFFFFF, 1'b1};
      ptab[14] = '{10'd320, 10'd512, 24'h000000, 1'b0};

      mtab[0] = '{1'b0, 1'b1, 10'd313};
      mtab[1] = '{1'b1, 1'b1, 10'd313};
      mtab[2] = '{1'b0, 1'b0, 10'd313};
      mtab[3] = '{1'b1, 1'b0, 10'd309};
      mtab[4] = '{1'b1, 1'b0, 10'd305};
      mtab[5] = '{1'b0, 1'b1, 10'd309};

      // Reset and idle frames
      step(); step(); step();
      chk_reset("rst");
      reset = 1'b0;
      ticks(3);
      chk("idle_pos", {22'd0, pos_x}, 32'd309);
      chk("idle_lives", {30'd0, lives}, 32'd3);

      for (int i = 0; i < 15; i++) begin
         pix($sformatf("pix%0d", i), ptab[i].ph, ptab[i].pv, ptab[i].rgb, ptab[i].on);
      end

      // Fire handshake and cooldown
      btn_fire = 1'b1;
      step();
      chk("fire_sv", {31'd0, shot_valid}, 32'd1);
      chk("fire_x", {22'd0, shot_x}, 32'd319);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("fire_hold_sv", {31'd0, shot_valid}, 32'd1);
      end
      shot_ready = 1'b1;
      step();
      shot_ready = 1'b0;
      chk("fire_accept", {31'd0, shot_valid}, 32'd0);
      btn_fire = 1'b0;
      step();
      ticks(14);
      btn_fire = 1'b1;
      step();
      chk("cool_drop", {31'd0, shot_valid}, 32'd0);
      btn_fire = 1'b0;
      step();
      tick();
      btn_fire = 1'b1;
      step();
      chk("cool_done", {31'd0, shot_valid}, 32'd1);
      btn_fire = 1'b0;
      shot_ready = 1'b1;
      step();
      shot_ready = 1'b0;
      chk("refire_accept", {31'd0, shot_valid}, 32'd0);

      // Movement table, then saturation at both walls
      for (int i = 0; i < 6; i++) begin
         btn_left  = mtab[i].l;
         btn_right = mtab[i].r;
         tick();
         chk($sformatf("move%0d", i), {22'd0, pos_x}, {22'd0, mtab[i].pos});
      end
      begin
         int max_pos;
         max_pos = 0;
         btn_left  = 1'b0;
         btn_right = 1'b1;
         for (int i = 0; i < 100; i++) begin
            tick();
            if (int'(pos_x) > max_pos) max_pos = int'(pos_x);
         end
         chk("sat_right_max", max_pos, 32'd618);
         chk("sat_right", {22'd0, pos_x}, 32'd618);
      end
      btn_left = 1'b1;
      ticks(3);
      chk("both_hold", {22'd0, pos_x}, 32'd618);
      btn_right = 1'b0;
      ticks(160);
      chk("sat_left", {22'd0, pos_x}, 32'd0);
      btn_right = 1'b1;
      tick();
      chk("both_hold0", {22'd0, pos_x}, 32'd0);
      btn_left  = 1'b0;
      btn_right = 1'b0;

      // Hit coincident with fire edge, then explosion blink and respawn
      hit      = 1'b1;
      btn_fire = 1'b1;
      step();
      hit      = 1'b0;
      btn_fire = 1'b0;
      chk("hitfire_sv", {31'd0, shot_valid}, 32'd0);
      chk("hit1_lives", {30'd0, lives}, 32'd2);
      pix("exp32", 10'd0, 10'd500, 24'h000000, 1'b0);
      btn_right = 1'b1;
      tick();
      pix("exp31", 10'd0, 10'd500, 24'hFF0000, 1'b1);
      ticks(3);
      pix("exp28", 10'd0, 10'd500, 24'hFF0000, 1'b1);
      tick();
      pix("exp27", 10'd0, 10'd500, 24'h000000, 1'b0);
      ticks(4);
      pix("exp23", 10'd0, 10'd500, 24'hFF0000, 1'b1);
      ticks(22);
      pix("exp1", 10'd0, 10'd500, 24'h000000, 1'b0);
      chk("exp_nomove", {22'd0, pos_x}, 32'd0);
      tick();
      btn_right = 1'b0;
      pix("dead0", 10'd0, 10'd500, 24'h000000, 1'b0);
      chk("dead_go", {31'd0, game_over}, 32'd0);
      ticks(59);
      pix("dead59", 10'd0, 10'd500, 24'h000000, 1'b0);
      chk("dead59_pos", {22'd0, pos_x}, 32'd0);
      tick();
      chk("respawn_pos", {22'd0, pos_x}, 32'd309);
      pix("respawn_pix", 10'd309, 10'd500, 24'hFFFFFF, 1'b1);

      // Second hit with a shot pending: the shot survives the explosion
      btn_fire = 1'b1;
      step();
      btn_fire = 1'b0;
      hit      = 1'b1;
      step();
      hit      = 1'b0;
      chk("hit2_lives", {30'd0, lives}, 32'd1);
      chk("hit2_sv_kept", {31'd0, shot_valid}, 32'd1);
      shot_ready = 1'b1;
      step();
      shot_ready = 1'b0;
      chk("hit2_accept", {31'd0, shot_valid}, 32'd0);
      ticks(92);
      chk("hit2_respawn", {22'd0, pos_x}, 32'd309);

      // Third hit ends the game
      hit = 1'b1;
      step();
      hit = 1'b0;
      chk("hit3_lives", {30'd0, lives}, 32'd0);
      ticks(31);
      chk("hit3_go_early", {31'd0, game_over}, 32'd0);
      tick();
      chk("hit3_go", {31'd0, game_over}, 32'd1);
      hit = 1'b1;
      step();
      hit       = 1'b0;
      btn_fire  = 1'b1;
      btn_right = 1'b1;
      ticks(3);
      btn_fire  = 1'b0;
      btn_right = 1'b0;
      chk("go_lives", {30'd0, lives}, 32'd0);
      chk("go_pos", {22'd0, pos_x}, 32'd309);
      chk("go_sv", {31'd0, shot_valid}, 32'd0);
      chk("go_sticky", {31'd0, game_over}, 32'd1);
      pix("go_pix", 10'd309, 10'd500, 24'h000000, 1'b0);

      // Reset from game over, then reset during a pending handshake
      reset = 1'b1;
      step();
      chk_reset("rst_go");
      reset = 1'b0;
      step();
      btn_fire = 1'b1;
      step();
      btn_fire = 1'b0;
      chk("hs_pending", {31'd0, shot_valid}, 32'd1);
      reset = 1'b1;
      step();
      chk_reset("rst_hs");
      reset = 1'b0;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
